// File: rtl/q2_phase_gen.sv
// q2_phase_gen: divides the master clock into NPHASE consecutive,
// non-overlapping phase windows of programmable width. It also generates
// the sc/ws cycle strobes and a count of completed machine cycles.
//
// Ports:
//   clk      master clock, rising edge
//   nreset   asynchronous active-low reset
//   nstart   active-low run request (level)
//   nstop    active-low stop request (level), beats nstart in IDLE
//   step     active-high single machine-cycle request (level)
//   div      clk cycles per phase, 0 treated as 1
//   cdiv     1 = alternate sc/ws per cycle, 0 = sc every cycle
//   phase    one-hot current phase, zero when idle
//   sc, ws   one-clk strobes at the first clk of phase[0]
//   running  high in RUN, STOP_PEND or STEP
//   cycles   completed machine cycles, wraps
module q2_phase_gen #(
  parameter int NPHASE    = 4,
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 nreset,
  input  logic                 nstart,
  input  logic                 nstop,
  input  logic                 step,
  input  logic [DIV_WIDTH-1:0] div,
  input  logic                 cdiv,
  output logic [NPHASE-1:0]    phase,
  output logic                 sc,
  output logic                 ws,
  output logic                 running,
  output logic [CNT_WIDTH-1:0] cycles
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOP_PEND,
    S_STEP
  } state_t;

  state_t                 state_q, state_d;
  logic [NPHASE-1:0]      phase_q, phase_d;
  logic [DIV_WIDTH-1:0]   prescale_q, prescale_d;
  logic [DIV_WIDTH-1:0]   div_eff_q, div_eff_d;
  logic                   cdiv_q, cdiv_d;
  logic                   parity_q, parity_d;
  logic                   sc_q, sc_d;
  logic                   ws_q, ws_d;
  logic                   running_q, running_d;
  logic [CNT_WIDTH-1:0]   cycles_q, cycles_d;

  logic [DIV_WIDTH-1:0]   div_in;
  logic                   last_tick;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    prescale_d = prescale_q;
    div_eff_d  = div_eff_q;
    cdiv_d     = cdiv_q;
    parity_d   = parity_q;
    running_d  = running_q;
    cycles_d   = cycles_q;
    sc_d       = 1'b0;
    ws_d       = 1'b0;

    div_in    = (div == '0) ? DIV_WIDTH'(1) : div;
    last_tick = (prescale_q == div_eff_q - DIV_WIDTH'(1));

    case (state_q)
      S_IDLE: begin
        // Stop beats start; start beats step.
        if (nstop && (!nstart || step)) begin
          state_d    = !nstart ? S_RUN : S_STEP;
          phase_d    = NPHASE'(1);
          prescale_d = '0;
          div_eff_d  = div_in;
          cdiv_d     = cdiv;
          parity_d   = 1'b0;
          running_d  = 1'b1;
          sc_d       = 1'b1;  // parity restarts at 0, so entry is always an sc cycle
        end
      end
      default: begin
        if (state_q == S_RUN && !nstop)
          state_d = S_STOP_PEND;

        if (!last_tick) begin
          prescale_d = prescale_q + DIV_WIDTH'(1);
        end else begin
          prescale_d = '0;
          if (phase_q[NPHASE-1]) begin
            // Machine-cycle boundary: count, flip parity, relatch settings.
            cycles_d  = cycles_q + CNT_WIDTH'(1);
            parity_d  = !parity_q;
            div_eff_d = div_in;
            cdiv_d    = cdiv;
            if (state_q == S_RUN) begin
              phase_d = NPHASE'(1);
              // Strobe choice follows the new cycle's parity and cdiv.
              sc_d    = !(cdiv && !parity_q);
              ws_d    = cdiv && !parity_q;
            end else begin
              state_d   = S_IDLE;
              phase_d   = '0;
              running_d = 1'b0;
            end
          end else begin
            phase_d = {phase_q[NPHASE-2:0], 1'b0};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      prescale_q <= '0;
      // Relatched on every IDLE exit, so this reset value is never observed.
      div_eff_q  <= DIV_WIDTH'(1);
      cdiv_q     <= 1'b0;
      parity_q   <= 1'b0;
      sc_q       <= 1'b0;
      ws_q       <= 1'b0;
      running_q  <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      prescale_q <= prescale_d;
      div_eff_q  <= div_eff_d;
      cdiv_q     <= cdiv_d;
      parity_q   <= parity_d;
      sc_q       <= sc_d;
      ws_q       <= ws_d;
      running_q  <= running_d;
      cycles_q   <= cycles_d;
    end
  end

  assign phase   = phase_q;
  assign sc      = sc_q;
  assign ws      = ws_q;
  assign running = running_q;
  assign cycles  = cycles_q;

endmodule
